// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU memory subsystem:
// default widths, starvation limit and the arbiter state encoding.
package cpu_pkg;

  localparam int AW_DEFAULT       = 16;
  localparam int DW_DEFAULT       = 16;
  localparam int MAX_WAIT_DEFAULT = 4;

  // Wide enough for any starvation limit in 1..15.
  localparam int AGE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DROP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_age.sv
// Saturating starvation counter for the fetch port: counts consecutive
// arbitrations lost to the data port and flags when the fetch must win.
module mem_arb_age
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             increment,
  input  logic [AGE_W-1:0] limit,
  output logic             win_i
);

  logic [AGE_W-1:0] age_reg;
  logic [AGE_W-1:0] age_next;

  always_comb begin
    age_next = age_reg;
    if (clear) begin
      age_next = '0;
    end else if (increment && (age_reg < limit)) begin
      age_next = age_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_reg <= '0;
    end else begin
      age_reg <= age_next;
    end
  end

  assign win_i = (age_reg == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the single-ported unified memory: one
// outstanding registered request, data priority with bounded fetch starvation.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_cancel,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  // data port
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  // memory side
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_done
);

  arb_state_e state_reg;
  arb_state_e state_next;

  logic          m_req_reg;
  logic          m_req_next;
  logic          m_wr_reg;
  logic          m_wr_next;
  logic [AW-1:0] m_addr_reg;
  logic [AW-1:0] m_addr_next;
  logic [DW-1:0] m_wdata_reg;
  logic [DW-1:0] m_wdata_next;

  logic             i_want;
  logic             grant_i;
  logic             grant_d;
  logic             win_i;
  logic             age_clear;
  logic             age_inc;
  logic [AGE_W-1:0] age_limit;

  // A fetch cancelled in the same cycle it is requested does not compete.
  assign i_want    = i_req & ~i_cancel;
  assign age_limit = AGE_W'(MAX_WAIT);
  assign age_clear = grant_i | ~i_req;
  assign age_inc   = grant_d & i_want;

  mem_arb_age u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (age_clear),
    .increment (age_inc),
    .limit     (age_limit),
    .win_i     (win_i)
  );

  always_comb begin
    state_next   = state_reg;
    m_req_next   = 1'b0;
    m_wr_next    = m_wr_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (d_req && !(i_want && win_i)) begin
          grant_d = 1'b1;
        end else if (i_want) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_next   = BUSY_D;
          m_req_next   = 1'b1;
          m_wr_next    = d_wr;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
        end else if (grant_i) begin
          // Fetches are reads; the write-data register keeps its old value.
          state_next  = BUSY_I;
          m_req_next  = 1'b1;
          m_wr_next   = 1'b0;
          m_addr_next = i_addr;
        end
      end

      BUSY_I: begin
        if (m_done) begin
          state_next = IDLE;
        end else if (i_cancel) begin
          state_next = DROP;
        end
      end

      BUSY_D: begin
        if (m_done) begin
          state_next = IDLE;
        end
      end

      DROP: begin
        // The cancelled fetch is still in flight; swallow its completion.
        if (m_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      m_req_reg   <= 1'b0;
      m_wr_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      m_req_reg   <= m_req_next;
      m_wr_reg    <= m_wr_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
    end
  end

  // Completions are only honoured for the owner of the outstanding access.
  assign i_valid = rst_n & (state_reg == BUSY_I) & m_done & ~i_cancel;
  assign d_valid = rst_n & (state_reg == BUSY_D) & m_done;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

  assign m_req   = m_req_reg;
  assign m_wr    = m_wr_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_cancel, d_req, d_wr, m_done;
  logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_valid, i_stall, d_valid, d_stall, m_req, m_wr;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAXW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_cancel (i_cancel),
    .i_valid  (i_valid),
    .i_rdata  (i_rdata),
    .i_stall  (i_stall),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_done   (m_done)
  );

  typedef struct {
    string       name;
    logic        ireq;
    logic        icancel;
    logic        dreq;
    logic        dwr;
    logic [15:0] iaddr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    int          grant;      // 0 none, 1 fetch, 2 data
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(string n, logic ir, logic ic, logic dr, logic dw,
                              logic [15:0] ia, logic [15:0] da, logic [15:0] dd,
                              int g, logic ew, logic [15:0] ea, logic [15:0] ed);
    vec_t v;
    v.name = n; v.ireq = ir; v.icancel = ic; v.dreq = dr; v.dwr = dw;
    v.iaddr = ia; v.daddr = da; v.dwdata = dd; v.grant = g;
    v.exp_wr = ew; v.exp_addr = ea; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_cancel = 0; i_addr = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    m_done = 0; m_rdata = 0;
  endtask

  // Leaves the bench in a fresh cycle with rst_n high and the arbiter idle.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      cyc_start();
      rst_n = 0;
      clear_inputs();
    end
    cyc_start();
    rst_n = 1;
  endtask

  // Inputs for the arbitration cycle are already applied by the caller.
  task automatic txn(input string tag, input int port, input logic [15:0] addr,
                     input logic wr, input logic [15:0] rdata);
    @(negedge clk);
    check1({tag, "_arb_mreq"}, m_req, 1'b0);
    cyc_start();
    @(negedge clk);
    check1({tag, "_mreq"}, m_req, 1'b1);
    check16({tag, "_maddr"}, m_addr, addr);
    check1({tag, "_mwr"}, m_wr, wr);
    cyc_start();
    m_done = 1; m_rdata = rdata;
    @(negedge clk);
    check1({tag, "_ivalid"}, i_valid, port == 1);
    check1({tag, "_dvalid"}, d_valid, port == 2);
    if (port == 1) check16({tag, "_irdata"}, i_rdata, rdata);
    if (port == 2 && !wr) check16({tag, "_drdata"}, d_rdata, rdata);
  endtask

  // Randomized-run model state
  int          owner;      // 0 free, 1 fetch, 2 data, 3 cancelled fetch
  int          lost;
  logic        exp_mreq, exp_wr;
  logic [15:0] exp_addr, exp_wdata;
  bit          prev_iv, prev_dv, prev_ic;
  bit          e_iv, e_dv, iw, gi, gd;
  int          done_at;

  initial begin
    rst_n = 0;
    clear_inputs();
    i_req = 1; i_addr = 16'h0040;

    // ---------------- reset ----------------
    cyc_start();
    @(negedge clk);
    check1("rst_mreq", m_req, 1'b0);
    check16("rst_maddr", m_addr, 16'h0000);
    check1("rst_mwr", m_wr, 1'b0);
    check16("rst_mwdata", m_wdata, 16'h0000);
    check1("rst_istall", i_stall, 1'b1);
    check1("rst_ivalid", i_valid, 1'b0);
    cyc_start();
    m_done = 1;
    @(negedge clk);
    check1("rst_done_ivalid", i_valid, 1'b0);
    check1("rst_done_dvalid", d_valid, 1'b0);
    cyc_start();
    rst_n = 1; i_req = 0; m_done = 1;
    @(negedge clk);
    check1("post_rst_done_ivalid", i_valid, 1'b0);
    check1("post_rst_done_dvalid", d_valid, 1'b0);
    cyc_start();
    m_done = 0;
    @(negedge clk);
    check1("post_rst_mreq", m_req, 1'b0);

    // ---------------- vector table ----------------
    vecs[0] = mk("fetch_only",   1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000);
    vecs[1] = mk("data_read",    0, 0, 1, 0, 16'h0000, 16'h1234, 16'h5555, 2, 0, 16'h1234, 16'h5555);
    vecs[2] = mk("data_write",   0, 0, 1, 1, 16'h0000, 16'h1000, 16'hBEEF, 2, 1, 16'h1000, 16'hBEEF);
    vecs[3] = mk("both_data",    1, 0, 1, 1, 16'h0002, 16'h2002, 16'h1111, 2, 1, 16'h2002, 16'h1111);
    vecs[4] = mk("fetch_cancel", 1, 1, 0, 0, 16'h0077, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    vecs[5] = mk("cancel_data",  1, 1, 1, 0, 16'h0088, 16'h3030, 16'h2222, 2, 0, 16'h3030, 16'h2222);
    vecs[6] = mk("nothing",      0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

    foreach (vecs[k]) begin
      do_reset(1);
      i_req = vecs[k].ireq; i_cancel = vecs[k].icancel; i_addr = vecs[k].iaddr;
      d_req = vecs[k].dreq; d_wr = vecs[k].dwr; d_addr = vecs[k].daddr;
      d_wdata = vecs[k].dwdata;
      @(negedge clk);
      check1({vecs[k].name, "_istall"}, i_stall, vecs[k].ireq);
      check1({vecs[k].name, "_dstall"}, d_stall, vecs[k].dreq);
      cyc_start();
      @(negedge clk);
      check1({vecs[k].name, "_mreq"}, m_req, vecs[k].grant != 0);
      check1({vecs[k].name, "_mwr"}, m_wr, vecs[k].exp_wr);
      check16({vecs[k].name, "_maddr"}, m_addr, vecs[k].exp_addr);
      check16({vecs[k].name, "_mwdata"}, m_wdata, vecs[k].exp_wdata);
      cyc_start();
      m_done = 1; m_rdata = 16'hC000 + 16'(k);
      @(negedge clk);
      check1({vecs[k].name, "_ivalid"}, i_valid, vecs[k].grant == 1);
      check1({vecs[k].name, "_dvalid"}, d_valid, vecs[k].grant == 2);
      if (vecs[k].grant == 1) check16({vecs[k].name, "_irdata"}, i_rdata, 16'hC000 + 16'(k));
      cyc_start();
      clear_inputs();
    end

    // ---------------- lone fetch ----------------
    do_reset(1);
    i_req = 1; i_addr = 16'h0040;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) begin m_done = 1; m_rdata = 16'hA5A5; end
      @(negedge clk);
      check1($sformatf("lone_mreq_c%0d", c), m_req, c == 1);
      check1($sformatf("lone_istall_c%0d", c), i_stall, c < 4);
      check1($sformatf("lone_ivalid_c%0d", c), i_valid, c == 4);
      if (c == 1) begin
        check16("lone_maddr", m_addr, 16'h0040);
        check1("lone_mwr", m_wr, 1'b0);
      end
      if (c == 4) check16("lone_irdata", i_rdata, 16'hA5A5);
      cyc_start();
    end
    i_req = 0; m_done = 0;
    @(negedge clk);
    check1("lone_after_mreq", m_req, 1'b0);

    // ---------------- conflict ----------------
    cyc_start();
    i_req = 1; i_addr = 16'h0002;
    d_req = 1; d_wr = 1; d_addr = 16'h1000; d_wdata = 16'hBEEF;
    cyc_start();
    @(negedge clk);
    check1("conf_mreq1", m_req, 1'b1);
    check1("conf_mwr1", m_wr, 1'b1);
    check16("conf_maddr1", m_addr, 16'h1000);
    check16("conf_mwdata1", m_wdata, 16'hBEEF);
    check1("conf_istall1", i_stall, 1'b1);
    cyc_start();
    m_done = 1; m_rdata = 16'h0BAD;
    @(negedge clk);
    check1("conf_dvalid", d_valid, 1'b1);
    check1("conf_ivalid", i_valid, 1'b0);
    check1("conf_dstall", d_stall, 1'b0);
    cyc_start();
    d_req = 0; m_done = 0;
    @(negedge clk);
    check1("conf_arb_mreq", m_req, 1'b0);
    cyc_start();
    @(negedge clk);
    check1("conf_mreq_i", m_req, 1'b1);
    check16("conf_maddr_i", m_addr, 16'h0002);
    check1("conf_mwr_i", m_wr, 1'b0);
    check16("conf_mwdata_held", m_wdata, 16'hBEEF);
    cyc_start();
    m_done = 1; m_rdata = 16'h1357;
    @(negedge clk);
    check1("conf_ivalid2", i_valid, 1'b1);
    check16("conf_irdata2", i_rdata, 16'h1357);
    cyc_start();
    clear_inputs();

    // ---------------- starvation (MAX_WAIT = 2) ----------------
    do_reset(1);
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_wr = 0; d_addr = 16'h2000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 2) txn($sformatf("starve_r%0d_i", r), 1, i_addr, 1'b0, 16'h7000 + 16'(r));
        else        txn($sformatf("starve_r%0d_d%0d", r, k), 2, d_addr, 1'b0, 16'h6000 + 16'(k));
        cyc_start();
        m_done = 0;
        if (k == 2) i_addr = i_addr + 16'd1;
        else        d_addr = d_addr + 16'd1;
      end
    end
    clear_inputs();

    // ---------------- cancel in BUSY_I ----------------
    do_reset(1);
    i_req = 1; i_addr = 16'h0300;
    cyc_start();
    @(negedge clk);
    check1("canc_mreq", m_req, 1'b1);
    cyc_start();
    i_cancel = 1; d_req = 1; d_wr = 0; d_addr = 16'h3000;
    @(negedge clk);
    check1("canc_ivalid0", i_valid, 1'b0);
    cyc_start();
    i_cancel = 0; i_req = 0;
    @(negedge clk);
    check1("canc_drop_mreq", m_req, 1'b0);
    check1("canc_dstall", d_stall, 1'b1);
    cyc_start();
    m_done = 1; m_rdata = 16'hDEAD;
    @(negedge clk);
    check1("canc_done_ivalid", i_valid, 1'b0);
    check1("canc_done_dvalid", d_valid, 1'b0);
    cyc_start();
    m_done = 0;
    @(negedge clk);
    check1("canc_arb_mreq", m_req, 1'b0);
    cyc_start();
    @(negedge clk);
    check1("canc_d_mreq", m_req, 1'b1);
    check16("canc_d_maddr", m_addr, 16'h3000);
    cyc_start();
    m_done = 1; m_rdata = 16'h4242; i_cancel = 1;
    @(negedge clk);
    check1("canc_busyd_dvalid", d_valid, 1'b1);
    check16("canc_busyd_drdata", d_rdata, 16'h4242);
    cyc_start();
    clear_inputs();

    // ---------------- cancel coincident with m_done ----------------
    cyc_start();
    i_req = 1; i_addr = 16'h0400;
    cyc_start();
    @(negedge clk);
    check1("cdone_mreq", m_req, 1'b1);
    cyc_start();
    m_done = 1; i_cancel = 1; m_rdata = 16'h9999;
    @(negedge clk);
    check1("cdone_ivalid", i_valid, 1'b0);
    check1("cdone_istall", i_stall, 1'b1);
    cyc_start();
    m_done = 0; i_cancel = 0; i_req = 0;
    d_req = 1; d_wr = 0; d_addr = 16'h4444;
    @(negedge clk);
    check1("cdone_arb_mreq", m_req, 1'b0);
    cyc_start();
    @(negedge clk);
    check1("cdone_idle_mreq", m_req, 1'b1);
    check16("cdone_idle_maddr", m_addr, 16'h4444);
    cyc_start();
    m_done = 1;
    cyc_start();
    clear_inputs();

    // ---------------- reset mid-access ----------------
    cyc_start();
    d_req = 1; d_wr = 1; d_addr = 16'h5000; d_wdata = 16'h1234;
    cyc_start();
    @(negedge clk);
    check1("rmid_mreq", m_req, 1'b1);
    cyc_start();
    rst_n = 0;
    @(negedge clk);
    check1("rmid_dvalid_rst", d_valid, 1'b0);
    check1("rmid_dstall_rst", d_stall, 1'b1);
    cyc_start();
    rst_n = 1; m_done = 1;
    @(negedge clk);
    check1("rmid_idle_mreq", m_req, 1'b0);
    check16("rmid_idle_maddr", m_addr, 16'h0000);
    check1("rmid_stale_dvalid", d_valid, 1'b0);
    cyc_start();
    m_done = 0;
    @(negedge clk);
    check1("rmid_reissue_mreq", m_req, 1'b1);
    check16("rmid_reissue_maddr", m_addr, 16'h5000);
    check1("rmid_reissue_mwr", m_wr, 1'b1);
    cyc_start();
    m_done = 1;
    @(negedge clk);
    check1("rmid_reissue_dvalid", d_valid, 1'b1);
    cyc_start();
    clear_inputs();

    // ---------------- randomized run vs model ----------------
    do_reset(1);
    owner = 0; lost = 0; exp_mreq = 0; exp_wr = 0; exp_addr = 0; exp_wdata = 0;
    prev_iv = 0; prev_dv = 0; prev_ic = 0; done_at = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) cyc_start();
      if (prev_iv || prev_ic) begin
        i_req = ($urandom_range(0, 2) != 0); i_addr = 16'($urandom);
      end else if (!i_req) begin
        i_req = ($urandom_range(0, 2) == 0); i_addr = 16'($urandom);
      end
      if (prev_dv || !d_req) begin
        d_req = prev_dv ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
        d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      i_cancel = i_req && ($urandom_range(0, 11) == 0);
      m_done   = (c == done_at);
      m_rdata  = 16'($urandom);
      @(negedge clk);

      e_iv = (owner == 1) && m_done && !i_cancel;
      e_dv = (owner == 2) && m_done;
      check1("rnd_ivalid", i_valid, e_iv);
      check1("rnd_dvalid", d_valid, e_dv);
      check1("rnd_one_valid", i_valid & d_valid, 1'b0);
      check1("rnd_istall", i_stall, i_req && !e_iv);
      check1("rnd_dstall", d_stall, d_req && !e_dv);
      check1("rnd_mreq", m_req, exp_mreq);
      if (exp_mreq) begin
        check16("rnd_maddr", m_addr, exp_addr);
        check1("rnd_mwr", m_wr, exp_wr);
        check16("rnd_mwdata", m_wdata, exp_wdata);
      end
      if (e_iv) check16("rnd_irdata", i_rdata, m_rdata);
      if (e_dv && !d_wr) check16("rnd_drdata", d_rdata, m_rdata);

      if (m_req) done_at = c + 1 + int'($urandom_range(0, 3));

      exp_mreq = 0;
      if (owner == 0) begin
        iw = i_req && !i_cancel;
        gi = iw && (!d_req || lost == MAXW);
        gd = d_req && !gi;
        if (gd) begin
          owner = 2; exp_mreq = 1; exp_addr = d_addr; exp_wr = d_wr; exp_wdata = d_wdata;
        end else if (gi) begin
          owner = 1; exp_mreq = 1; exp_addr = i_addr; exp_wr = 0;
        end
        if (gi || !i_req) lost = 0;
        else if (gd && iw && lost < MAXW) lost++;
      end else begin
        if (owner == 1 && !m_done && i_cancel) owner = 3;
        else if (m_done) owner = 0;
        if (!i_req) lost = 0;
      end
      prev_iv = e_iv; prev_dv = e_dv; prev_ic = i_cancel;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the 16-bit pipelined CPU. Requesters hold level requests, and the block returns per-port stall signals that feed the pipeline stall/flush logic. It drives a registered request to a variable-latency memory, allows one outstanding transaction, and supports cancellation of a fetch killed by a control-flow flush. Data has priority, with an age counter that bounds instruction-fetch starvation.

## Interface
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 4, consecutive lost arbitrations after which the fetch port wins (1..15)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous and active-low (one clock; reset is synchronous, active-low)
- i_req  in  1  fetch request, held until i_valid or i_cancel
- i_addr  in  AW  fetch address, stable while i_req
- i_cancel  in  1  discard the current/pending fetch (pulse)
- i_valid  out  1  fetch completes this cycle
- i_rdata  out  DW  fetched word, valid with i_valid
- i_stall  out  1  i_req & ~i_valid
- d_req  in  1  data request, held until d_valid
- d_wr  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_valid  out  1  data access completes this cycle
- d_rdata  out  DW  read word, valid with d_valid & ~d_wr
- d_stall  out  1  d_req & ~d_valid
- m_req  out  1  one-cycle issue pulse, registered
- m_wr  out  1  registered write flag
- m_addr  out  AW  registered address
- m_wdata  out  DW  registered write data
- m_rdata  in  DW  memory read data, valid with m_done
- m_done  in  1  one-cycle completion, ≥1 cycle after m_req

## Operation
- States: IDLE, BUSY_I, BUSY_D, DROP.
- IDLE, arbitration:
  - d_req wins over i_req unless age == MAX_WAIT; then i_req wins.
  - i_req with i_cancel in the same cycle is not a request.
  - Winner: m_req/m_wr/m_addr/m_wdata registered at the edge, then go to BUSY_I or BUSY_D.
  - Fetch issue: m_wr = 0, m_wdata holds its previous value.
- Age counter: increments at each IDLE edge where both ports request and data wins; clears when a fetch is granted or i_req is low. Saturates at MAX_WAIT.
- BUSY_I:
  - m_done → i_valid = 1 combinationally, i_rdata = m_rdata; next state IDLE.
  - i_cancel without m_done → DROP.
  - i_cancel with m_done → i_valid suppressed; next state IDLE.
- BUSY_D: m_done → d_valid = 1, d_rdata = m_rdata; next state IDLE. On writes d_rdata is don't-care.
- DROP: m_done → IDLE with no valid. Requests wait.
- m_done in IDLE is ignored (stale completion after reset).
- i_cancel in BUSY_D or DROP has no effect.
- d_valid and i_valid are never high in the same cycle.

## Timing
- Reset values: state IDLE, age 0, m_req 0, m_wr 0, m_addr 0, m_wdata 0.
- i_valid/d_valid are 0 during reset. Stalls follow the req inputs.
- Request seen in cycle 0 (IDLE) → m_req high in cycle 1 only. m_done in cycle n ≥ 2 → valid in cycle n.
- Back-to-back: IDLE in cycle n+1 can issue, so m_req is in cycle n+2. There is no idle cycle beyond that arbitration cycle.
- Requester updates req/addr at the edge ending the valid cycle.
- Reset mid-transaction: goes to IDLE at once. An in-flight m_done is ignored and no valid is produced.

## Structure
- Shared package cpu_pkg:
  - state enum (IDLE, BUSY_I, BUSY_D, DROP)
  - AW/DW defaults
  - MAX_WAIT default
- One sub-module, mem_arb_age: the saturating starvation counter. Inputs are clear, increment and limit; output is win_i.
- The rest is a single FSM plus output registers. Stall/valid logic is combinational.

## Test plan
- Reset: rst_n low 2 cycles with i_req = 1 → m_req = 0, m_addr = 0, i_stall = 1, i_valid = 0; a m_done pulse during/after reset produces no valid.
- Lone fetch: i_addr 0x0040 at cycle 0, m_done at cycle 4 with m_rdata 0xA5A5 → m_req only in cycle 1, m_addr 0x0040, m_wr 0; i_valid/i_rdata 0xA5A5 in cycle 4; i_stall 1 in cycles 0–3.
- Conflict: i_req 0x0002 and d_req write 0x1000/0xBEEF at cycle 0 → cycle 1 m_wr 1, m_addr 0x1000, m_wdata 0xBEEF; after d_valid, fetch m_req one cycle after the following arbitration cycle.
- Starvation: MAX_WAIT = 2, d_req held with new addresses each completion, i_req held → the third arbitration grants the fetch, then the age counter is 0.
- Cancel: fetch issued, i_cancel in BUSY_I, d_req raised → m_done yields no i_valid; data m_req two cycles later. i_cancel coincident with m_done → no i_valid.
- Reset mid-access: rst_n low in BUSY_D → next cycle IDLE, m_req 0; later m_done is ignored and d_req is reissued after reset.
